iir_out_decimator: RTL and testbench
====================================

# iir_out_decimator

Downstream stage of the first-order IIR filter. Consumes the filter's 13-bit signed integer output (the `y` register, bits [24:12]) at the filter rate and applies boxcar accumulate-and-dump decimation by DECIM. Each average is saturated to OUT_W bits and buffered in a small FIFO. The FIFO drains over a valid/ready handshake to the next consumer (DAC or host interface).

## Interface
- DECIM, 4: decimation ratio; power of two, 2..16.
- OUT_W, 8: output sample width, signed, 4..13.
- FIFO_DEPTH, 4: output FIFO entries; power of two, 2..16.
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  data_in is a new filter sample this cycle.
- data_in  in  13  signed filter output sample, integer-scaled.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head this cycle.
- out_data  out  OUT_W  signed decimated sample (FIFO head).
- sat  out  1  one-cycle pulse: the block just pushed was clamped.
- ovf  out  1  sticky: a block was dropped because the FIFO was full.
- clr_ovf  in  1  synchronous clear of ovf.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Accumulator acc is signed, width 13+log2(DECIM). Phase counter cnt runs 0..DECIM-1. Both advance only on in_valid.
- in_valid with cnt<DECIM-1: acc<=acc+data_in; cnt<=cnt+1.
- in_valid with cnt==DECIM-1: compute total=acc+data_in, then avg=total>>>log2(DECIM). The shift is arithmetic, so it rounds toward minus infinity.
  - Saturate avg to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and push the result.
  - acc<=0; cnt<=0.
  - sat pulses for one cycle if clamping occurred.
- in_valid low: acc and cnt hold. Gaps are allowed anywhere inside a block.
- FIFO is first-word-fall-through: out_data shows the head whenever out_valid=1. A pop occurs when out_valid and out_ready are both high.
- Push into a full FIFO with no pop in the same cycle: the new sample is dropped, ovf<=1, FIFO unchanged.
- Push and pop in the same cycle: always accepted, including when full. level is unchanged.
- Pop when empty: ignored.
- clr_ovf and a new overflow in the same cycle: ovf ends at 1, because the set wins.
- out_data holds its last value when out_valid=0. It is not required to be zero.

## Timing
- Reset values:
  - acc=0, cnt=0, FIFO empty, level=0.
  - out_valid=0, out_data=0, sat=0, ovf=0.
- Latency: the sample completing a block is accepted on edge N. out_valid rises and out_data is valid after edge N, i.e. it is observable before edge N+1.
- sat asserts in the same cycle as out_valid/level reflect the push.
- Throughput: one push per DECIM accepted inputs and one pop per cycle. Back-to-back pops are supported.
- Reset mid-block discards partial accumulation; the next block starts at cnt=0.
- Reset mid-drain empties the FIFO. out_valid drops asynchronously.
- No combinational path from out_ready to out_valid or out_data. level updates one edge after a push or pop.

## Structure
- Package iir_pkg: Y_W=13 (filter output width) and shared DECIM/OUT_W defaults. Filter and decimator import both.
- Saturation is a function in iir_pkg, sat_signed(value, width), reused by later requantizers.
- Sub-module sync_fifo holds the storage, pointers, level, and the full/empty logic. It is parameterised on width and depth and has FWFT output. The top level contains the accumulator, counter, saturation, and flags.

## Test plan
- DECIM=4, out_ready=1, inputs 10,20,30,40 on consecutive cycles -> single out_data=25, out_valid high one cycle after the 40 is accepted; sat=0.
- Inputs -3,-3,-3,-2 -> total -11, out_data=-3 (floor). Inputs 1000×4 -> out_data=127, sat pulse. Inputs -4000×4 -> out_data=-128, sat pulse.
- Hold out_ready=0 and feed 5 full blocks of constant values 1..5 -> level=4, ovf=1, fifth block lost. Then out_ready=1 -> outputs 1,2,3,4 on consecutive cycles, level returns to 0. clr_ovf -> ovf=0.
- in_valid toggled irregularly (2 on, 3 off, 2 on) with inputs 8,8,8,8 -> exactly one output of 8, emitted after the fourth valid sample.
- Assert reset_n low after 2 samples of a block -> outputs at reset values immediately. After release, 4 samples of 4 -> out_data=4 with no contribution from the pre-reset samples.
- With the FIFO full and out_ready=1, complete a block on the same cycle as a pop -> push accepted, level stays 4, ovf stays 0.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared constants and helpers for the first-order IIR filter and its downstream stages.
package iir_pkg;

  localparam int unsigned Y_W       = 13;
  localparam int unsigned DECIM_DEF = 4;
  localparam int unsigned OUT_W_DEF = 8;

  // Clamp a signed value into the signed range of 'width' bits (width <= 31).
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int unsigned      width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (width - 1));
    if (value > max_v) begin
      sat_signed = max_v;
    end else if (value < min_v) begin
      sat_signed = min_v;
    end else begin
      sat_signed = value;
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible on out_data while out_valid is high.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop_ready,
  output logic                     out_valid,
  output logic [Width-1:0]         out_data,
  output logic                     full,
  output logic [$clog2(Depth):0]   level
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             pop, push_ok;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == (PtrW + 1)'(Depth));
  assign pop       = out_valid && pop_ready;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign push_ok   = push && (!full || pop);
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/iir_out_decimator.sv
// Boxcar accumulate-and-dump decimator for the IIR filter output, with saturation and an
// output FIFO drained over valid/ready.
module iir_out_decimator
  import iir_pkg::*;
#(
  parameter int unsigned DECIM      = DECIM_DEF,
  parameter int unsigned OUT_W      = OUT_W_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  input  logic signed [Y_W-1:0]           data_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [OUT_W-1:0]         out_data,
  output logic                            sat,
  output logic                            ovf,
  input  logic                            clr_ovf,
  output logic [$clog2(FIFO_DEPTH):0]     level
);

  localparam int unsigned DecimLog = $clog2(DECIM);
  localparam int unsigned AccW     = Y_W + DecimLog;

  logic signed [AccW-1:0]  acc_q, acc_d;
  logic [DecimLog-1:0]     cnt_q, cnt_d;
  logic                    sat_q, sat_d;
  logic                    ovf_q, ovf_d;

  logic signed [AccW-1:0]  data_ext, total, avg;
  logic signed [31:0]      avg_ext, sat_val;
  logic                    last, push, clamped, full, pop, drop;
  logic [OUT_W-1:0]        fifo_out;

  assign data_ext = {{DecimLog{data_in[Y_W-1]}}, data_in};
  assign total    = acc_q + data_ext;
  // Arithmetic shift floors the average toward minus infinity.
  assign avg      = total >>> DecimLog;
  assign avg_ext  = {{(32 - AccW){avg[AccW-1]}}, avg};
  assign sat_val  = sat_signed(avg_ext, OUT_W);
  assign clamped  = (sat_val != avg_ext);

  assign last = (cnt_q == DecimLog'(DECIM - 1));
  assign push = in_valid && last;
  assign pop  = out_valid && out_ready;
  assign drop = push && full && !pop;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    sat_d = 1'b0;
    ovf_d = ovf_q;
    if (in_valid) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
        sat_d = clamped && !drop;
      end else begin
        acc_d = total;
        cnt_d = cnt_q + DecimLog'(1);
      end
    end
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
      ovf_q <= ovf_d;
    end
  end

  sync_fifo #(
    .Width (OUT_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (sat_val[OUT_W-1:0]),
    .pop_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (fifo_out),
    .full      (full),
    .level     (level)
  );

  assign out_data = fifo_out;
  assign sat      = sat_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_iir_out_decimator.sv
// Directed self-checking bench for iir_out_decimator (DECIM=4, OUT_W=8, FIFO_DEPTH=4).
module tb_iir_out_decimator;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic signed [12:0] data_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic               sat;
  logic               ovf;
  logic               clr_ovf;
  logic [2:0]         level;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iir_out_decimator #(
    .DECIM      (4),
    .OUT_W      (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat       (sat),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf),
    .level     (level)
  );

  // Apply one cycle of input, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic signed [12:0] d);
    in_valid = v;
    data_in  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'sd0 || sat !== 1'b0 || ovf !== 1'b0
        || level !== 3'd0) begin
      failures++;
      $display("FAIL reset_values: valid=%b data=%0d sat=%b ovf=%b level=%0d, want 0 0 0 0 0",
               out_valid, out_data, sat, ovf, level);
    end
  endtask

  task automatic test_average();
    logic signed [12:0] vals [4];
    vals = '{13'sd10, 13'sd20, 13'sd30, 13'sd40};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, vals[i]);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL avg_early_valid: sample %0d valid=%b, want 0", i, out_valid);
      end
    end
    step(1'b1, vals[3]);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'sd25 || sat !== 1'b0 || level !== 3'd1) begin
      failures++;
      $display("FAIL avg_25: valid=%b data=%0d sat=%b level=%0d, want 1 25 0 1",
               out_valid, out_data, sat, level);
    end
    step(1'b0, 13'sd0);
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      failures++;
      $display("FAIL avg_popped: valid=%b level=%0d, want 0 0", out_valid, level);
    end
  endtask

  task automatic test_floor();
    out_ready = 1'b1;
    step(1'b1, -13'sd3);
    step(1'b1, -13'sd3);
    step(1'b1, -13'sd3);
    step(1'b1, -13'sd2);
    checks++;
    if (out_valid !== 1'b1 || out_data !== -8'sd3 || sat !== 1'b0) begin
      failures++;
      $display("FAIL floor_neg: valid=%b data=%0d sat=%b, want 1 -3 0", out_valid, out_data, sat);
    end
    step(1'b0, 13'sd0);
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    repeat (4) step(1'b1, 13'sd1000);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'sd127 || sat !== 1'b1) begin
      failures++;
      $display("FAIL sat_pos: valid=%b data=%0d sat=%b, want 1 127 1", out_valid, out_data, sat);
    end
    step(1'b0, 13'sd0);
    checks++;
    if (sat !== 1'b0) begin
      failures++;
      $display("FAIL sat_pulse_width: sat=%b, want 0", sat);
    end
    repeat (4) step(1'b1, -13'sd4000);
    checks++;
    if (out_valid !== 1'b1 || out_data !== -8'sd128 || sat !== 1'b1) begin
      failures++;
      $display("FAIL sat_neg: valid=%b data=%0d sat=%b, want 1 -128 1", out_valid, out_data, sat);
    end
    step(1'b0, 13'sd0);
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      repeat (4) step(1'b1, 13'(b));
      if (b == 4) begin
        checks++;
        if (level !== 3'd4 || ovf !== 1'b0) begin
          failures++;
          $display("FAIL ovf_fill: level=%0d ovf=%b, want 4 0", level, ovf);
        end
      end
    end
    checks++;
    if (level !== 3'd4 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drop: level=%0d ovf=%b, want 4 1", level, ovf);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(k)) begin
        failures++;
        $display("FAIL ovf_drain: item %0d valid=%b data=%0d, want 1 %0d",
                 k, out_valid, out_data, k);
      end
      step(1'b0, 13'sd0);
    end
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drained: level=%0d valid=%b ovf=%b, want 0 0 1", level, out_valid, ovf);
    end
    clr_ovf = 1'b1;
    step(1'b0, 13'sd0);
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: ovf=%b, want 0", ovf);
    end
  endtask

  task automatic test_gaps();
    logic pattern [7];
    pattern = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(pattern[i], 13'sd8);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL gap_early: cycle %0d valid=%b, want 0", i, out_valid);
      end
    end
    step(pattern[6], 13'sd8);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'sd8 || level !== 3'd1) begin
      failures++;
      $display("FAIL gap_out: valid=%b data=%0d level=%0d, want 1 8 1", out_valid, out_data, level);
    end
    step(1'b0, 13'sd0);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    repeat (4) step(1'b1, 13'sd7);
    step(1'b1, 13'sd100);
    step(1'b1, 13'sd100);
    checks++;
    if (out_valid !== 1'b1 || level !== 3'd1) begin
      failures++;
      $display("FAIL rst_pre: valid=%b level=%0d, want 1 1", out_valid, level);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'sd0 || level !== 3'd0 || sat !== 1'b0
        || ovf !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: valid=%b data=%0d level=%0d sat=%b ovf=%b, want 0 0 0 0 0",
               out_valid, out_data, level, sat, ovf);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) step(1'b1, 13'sd4);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_partial: valid=%b after 3 post-reset samples, want 0", out_valid);
    end
    step(1'b1, 13'sd4);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'sd4) begin
      failures++;
      $display("FAIL rst_fresh: valid=%b data=%0d, want 1 4", out_valid, out_data);
    end
    step(1'b0, 13'sd0);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int b = 11; b <= 14; b++) begin
      repeat (4) step(1'b1, 13'(b));
    end
    repeat (3) step(1'b1, 13'sd15);
    checks++;
    if (level !== 3'd4 || out_data !== 8'sd11) begin
      failures++;
      $display("FAIL full_pre: level=%0d data=%0d, want 4 11", level, out_data);
    end
    out_ready = 1'b1;
    step(1'b1, 13'sd15);
    checks++;
    if (level !== 3'd4 || ovf !== 1'b0 || out_data !== 8'sd12) begin
      failures++;
      $display("FAIL full_push_pop: level=%0d ovf=%b data=%0d, want 4 0 12", level, ovf, out_data);
    end
    for (int k = 12; k <= 15; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(k)) begin
        failures++;
        $display("FAIL b2b_drain: valid=%b data=%0d, want 1 %0d", out_valid, out_data, k);
      end
      step(1'b0, 13'sd0);
    end
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_empty: level=%0d valid=%b, want 0 0", level, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_average();
    test_floor();
    test_saturation();
    test_overflow();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
